// File: rtl/pc_branch_unit_if.sv
// Bus between the condition mux/decode side and the PC update stage.
// The master drives instruction and condition inputs; the slave returns PC state.
interface pc_branch_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             branch;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic [15:0]      branch_offset;
  logic             cond_valid;
  logic             cond_taken;
  logic             exc;
  logic [WIDTH-1:0] pc;
  logic             pc_write;
  logic             busy;
  logic             taken;
  logic             timeout;

  modport master (
    output start, branch, jump, jump_target, branch_offset,
    output cond_valid, cond_taken, exc,
    input  pc, pc_write, busy, taken, timeout
  );

  modport slave (
    input  start, branch, jump, jump_target, branch_offset,
    input  cond_valid, cond_taken, exc,
    output pc, pc_write, busy, taken, timeout
  );
endinterface

// File: rtl/pc_branch_unit.sv
// PC register and next-PC resolution: sequential, jump, or conditional branch
// with a bounded wait for the condition bit; exceptions override everything.
module pc_branch_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_00FF,
  parameter int               MAX_WAIT   = 8
) (
  input  logic               clk,
  input  logic               reset,
  pc_branch_unit_if.slave    bus
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_COND, UPDATE, EXC} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic [15:0]      offset_q;
  logic [CW-1:0]    wait_cnt;
  logic             taken_q;
  logic             timeout_q;

  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_br;

  // Offset is a signed word count: sign-extend, then scale to bytes.
  always_comb begin
    pc_seq = pc_q + WIDTH'(4);
    pc_br  = pc_seq + {{(WIDTH-18){offset_q[15]}}, offset_q, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      next_pc   <= RESET_PC;
      offset_q  <= '0;
      wait_cnt  <= '0;
      taken_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.exc) begin
            offset_q <= bus.branch_offset;
            if (bus.jump) begin
              next_pc <= bus.jump_target;
              state   <= UPDATE;
            end else if (bus.branch) begin
              wait_cnt <= '0;
              state    <= WAIT_COND;
            end else begin
              next_pc <= pc_seq;
              state   <= UPDATE;
            end
          end
        end
        WAIT_COND: begin
          if (!bus.exc) begin
            if (bus.cond_valid) begin
              next_pc   <= bus.cond_taken ? pc_br : pc_seq;
              taken_q   <= bus.cond_taken;
              timeout_q <= 1'b0;
              state     <= UPDATE;
            end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
              next_pc   <= pc_seq;
              taken_q   <= 1'b0;
              timeout_q <= 1'b1;
              state     <= UPDATE;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end
        end
        UPDATE: begin
          pc_q  <= next_pc;
          state <= IDLE;
        end
        EXC: begin
          pc_q      <= EXC_VECTOR;
          taken_q   <= 1'b0;
          timeout_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Exception wins over whatever transition was chosen above.
      if (bus.exc) state <= EXC;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_write = (state == UPDATE) || (state == EXC);
  assign bus.busy     = (state != IDLE);
  assign bus.taken    = taken_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed table-driven bench for pc_branch_unit plus a mid-operation reset sequence.
module tb_pc_branch_unit;

  localparam int MAXW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_branch_unit_if #(.WIDTH(32)) bus ();

  pc_branch_unit #(
    .WIDTH(32),
    .RESET_PC(32'h0),
    .EXC_VECTOR(32'h0000_00FF),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        jump;
    logic        branch;
    logic [31:0] target;
    logic [15:0] offset;
    int          cond_cycle;
    logic        cond_taken;
    logic        early_cond;
    int          extra_start;
    int          exc_cycle;
    int          exp_pw;
    int          exp_busy;
    logic [31:0] exp_pc;
    logic        exp_taken;
    logic        exp_timeout;
  } vec_t;

  vec_t vecs[15];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0;
    bus.jump_target = '0; bus.branch_offset = '0;
    bus.cond_valid = 1'b0; bus.cond_taken = 1'b0; bus.exc = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, output int pw_cycle, output int pw_count, output int busy_count);
    pw_cycle = -1; pw_count = 0; busy_count = 0;
    @(posedge clk); #1;
    for (int c = 0; c < MAXW + 6; c++) begin
      if (c == 0) begin
        bus.start = 1'b1; bus.jump = v.jump; bus.branch = v.branch;
        bus.jump_target = v.target; bus.branch_offset = v.offset;
      end else if (c == v.extra_start) begin
        bus.start = 1'b1; bus.jump = 1'b1; bus.branch = 1'b0;
        bus.jump_target = 32'h500; bus.branch_offset = 16'h7FFF;
      end else begin
        bus.start = 1'b0; bus.jump = 1'b0; bus.branch = 1'b0;
        bus.jump_target = '0; bus.branch_offset = '0;
      end
      bus.cond_valid = (c == v.cond_cycle) || (c == 0 && v.early_cond);
      bus.cond_taken = (c == 0 && v.early_cond) ? 1'b1 : v.cond_taken;
      bus.exc = (c == v.exc_cycle);
      @(negedge clk);
      if (bus.pc_write) begin
        if (pw_count == 0) pw_cycle = c;
        pw_count++;
      end
      if (bus.busy) busy_count++;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    int pw_cycle, pw_count, busy_count;
    //        jmp  br   target        offset    cc  ct   ec   xs  exc pw busy exp_pc        tk   to
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        16'h0,    -1, 1'b0, 1'b0, -1, -1, 1, 1, 32'h0000_0004, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h100,      16'h0,    -1, 1'b0, 1'b0, -1, -1, 1, 1, 32'h0000_0100, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0,        16'hFFFE,  3, 1'b1, 1'b0, -1, -1, 4, 4, 32'h0000_00FC, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h100,      16'h0,    -1, 1'b0, 1'b0, -1, -1, 1, 1, 32'h0000_0100, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0,        16'h0005,  1, 1'b0, 1'b1, -1, -1, 2, 2, 32'h0000_0104, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,        16'h0003, -1, 1'b0, 1'b0,  5, -1, 9, 9, 32'h0000_0108, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,        16'h0001,  1, 1'b1, 1'b0, -1, -1, 2, 2, 32'h0000_0110, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h400,      16'h0,    -1, 1'b0, 1'b0, -1,  0, 1, 1, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h100,      16'h0,    -1, 1'b0, 1'b0, -1, -1, 1, 1, 32'h0000_0100, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0,        16'h0004,  3, 1'b1, 1'b0, -1,  3, 4, 4, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 16'h0,   -1, 1'b0, 1'b0, -1, -1, 1, 1, 32'hFFFF_FFFC, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        16'h0,    -1, 1'b0, 1'b0, -1, -1, 1, 1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0,        16'hFFFE,  2, 1'b1, 1'b0, -1, -1, 3, 3, 32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h0,        16'h7FFF,  1, 1'b1, 1'b0, -1, -1, 2, 2, 32'h0001_FFFC, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0,        16'h0001,  8, 1'b1, 1'b0, -1, -1, 9, 9, 32'h0002_0004, 1'b1, 1'b0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_pc", bus.pc, 32'h0);
    check("reset_pc_write", {31'b0, bus.pc_write}, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_taken", {31'b0, bus.taken}, 32'h0);
    check("reset_timeout", {31'b0, bus.timeout}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], pw_cycle, pw_count, busy_count);
      check($sformatf("v%0d_pw_cycle", i), pw_cycle, vecs[i].exp_pw);
      check($sformatf("v%0d_pw_count", i), pw_count, 32'd1);
      check($sformatf("v%0d_busy_cycles", i), busy_count, vecs[i].exp_busy);
      check($sformatf("v%0d_pc", i), bus.pc, vecs[i].exp_pc);
      check($sformatf("v%0d_taken", i), {31'b0, bus.taken}, {31'b0, vecs[i].exp_taken});
      check($sformatf("v%0d_timeout", i), {31'b0, bus.timeout}, {31'b0, vecs[i].exp_timeout});
    end

    // Reset while waiting for the condition; a late cond_valid must not land.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.branch = 1'b1; bus.branch_offset = 16'h0001;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("midrst_busy_before", {31'b0, bus.busy}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cond_valid = 1'b1; bus.cond_taken = 1'b1;
    @(negedge clk);
    check("midrst_pc", bus.pc, 32'h0);
    check("midrst_busy", {31'b0, bus.busy}, 32'h0);
    check("midrst_taken", {31'b0, bus.taken}, 32'h0);
    @(posedge clk); #1;
    bus.cond_valid = 1'b0; bus.cond_taken = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst_after%0d_pw", c), {31'b0, bus.pc_write}, 32'h0);
      check($sformatf("midrst_after%0d_pc", c), bus.pc, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
